ibuf_drain_sched: RTL and testbench

//  Drain scheduler for the internal rx buffer (ibuf) filled by the backend-to-ibuf writer.
//  - Tracks the producer's committed pointer against its own consumer pointer.
//  - Checks host buffer credits.
//  - Issues chunked DMA read requests (ibuf -> host) and advances committed_cons on completion.
//  - Owns hst_rdy, the gate that starts the producer.

---
 rtl/ibuf_drain_sched.sv | 147 ++++++++++++++
 tb/tb_ibuf_drain_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibuf_drain_sched.sv
// ibuf_drain_sched
//   Drain scheduler for the internal rx buffer (ibuf). Compares the writer's
//   committed pointer against the local consumer pointer, checks host credits,
//   issues one chunked DMA read (ibuf -> host) at a time, and releases ibuf
//   space back to the writer when the read completes. Also owns hst_rdy, the
//   gate that lets the ibuf writer start accepting frames.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   hst_en          host driver enabled (level)
//   hst_rdy         ibuf writer may start accepting frames
//   activity        writer wrote ibuf this cycle
//   committed_prod  writer's committed pointer (BW+1 bits, wrap bit on top)
//   committed_cons  qwords released back to the writer (BW+1 bits)
//   cred_add        pulse: host returned one receive buffer
//   credits         current host credit count (saturates at 255)
//   dma_req         request valid, held until dma_ack
//   dma_addr        ibuf start qword address of the request
//   dma_qw          qword count of the request, 1..CHUNK_QW
//   dma_ack         request accepted (only honoured while dma_req=1)
//   dma_done        pulse: accepted request fully read (only honoured in XFER)
module ibuf_drain_sched #(
    parameter int unsigned BW       = 10,
    parameter int unsigned CHUNK_QW = 32,
    parameter int unsigned IDLE_TMO = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hst_en,
    output logic          hst_rdy,
    input  logic          activity,
    input  logic [BW:0]   committed_prod,
    output logic [BW:0]   committed_cons,
    input  logic          cred_add,
    output logic [7:0]    credits,
    output logic          dma_req,
    output logic [BW-1:0] dma_addr,
    output logic [BW:0]   dma_qw,
    input  logic          dma_ack,
    input  logic          dma_done
);

    localparam int unsigned  IW    = $clog2(IDLE_TMO + 1);
    localparam logic [BW:0]  DEPTH = {1'b1, {BW{1'b0}}};
    localparam logic [BW:0]  CHUNK = (BW+1)'(CHUNK_QW);
    localparam logic [IW-1:0] TMO  = IW'(IDLE_TMO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_REQ,
        S_XFER
    } state_t;

    state_t        state;
    logic [IW-1:0] idle_cnt;

    logic [BW:0]   pending;
    logic [BW:0]   room;
    logic [BW:0]   len;
    logic          eligible;
    logic          dispatch;

    // Request sizing: never more than a chunk, never past the ibuf end.
    // A short request goes out only when it is forced by the ibuf end or the
    // writer has gone quiet for IDLE_TMO cycles.
    always_comb begin
        pending = committed_prod - committed_cons;
        room    = DEPTH - {1'b0, committed_cons[BW-1:0]};
        len     = pending;
        if (CHUNK < len) len = CHUNK;
        if (room < len)  len = room;
        eligible = hst_en && (credits != '0) && (pending != '0) &&
                   ((len == CHUNK) || (len == room) || (idle_cnt == TMO));
        dispatch = (state == S_WAIT) && eligible;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            idle_cnt       <= '0;
            hst_rdy        <= 1'b0;
            committed_cons <= '0;
            credits        <= '0;
            dma_req        <= 1'b0;
            dma_addr       <= '0;
            dma_qw         <= '0;
        end else begin
            if (activity || dispatch)
                idle_cnt <= '0;
            else if (idle_cnt != TMO)
                idle_cnt <= idle_cnt + IW'(1);

            // A returned credit on the dispatch cycle cancels the one consumed.
            if (dispatch) begin
                if (!cred_add)
                    credits <= credits - 8'd1;
            end else if (cred_add && (credits != 8'hFF)) begin
                credits <= credits + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    hst_rdy <= 1'b0;
                    if (hst_en)
                        state <= S_ARM;
                end
                S_ARM: begin
                    hst_rdy <= 1'b1;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (!hst_en) begin
                        hst_rdy <= 1'b0;
                        state   <= S_IDLE;
                    end else if (eligible) begin
                        dma_req  <= 1'b1;
                        dma_addr <= committed_cons[BW-1:0];
                        dma_qw   <= len;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!hst_en)
                        hst_rdy <= 1'b0;
                    if (dma_ack) begin
                        dma_req <= 1'b0;
                        state   <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!hst_en)
                        hst_rdy <= 1'b0;
                    // hst_rdy doubles as the "host dropped mid-flight" flag:
                    // once cleared, the completion returns to IDLE.
                    if (dma_done) begin
                        committed_cons <= committed_cons + dma_qw;
                        state          <= (hst_en && hst_rdy) ? S_WAIT : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibuf_drain_sched.sv
// tb_ibuf_drain_sched
//   Self-checking bench for ibuf_drain_sched (BW=10, CHUNK_QW=32, IDLE_TMO=64).
//   A cycle-level reference model built from plain integer arithmetic predicts
//   every output after every clock edge; directed steps add explicit checks on
//   the key scenarios, then a randomized phase exercises the whole protocol.
module tb_ibuf_drain_sched;

    localparam int BW    = 10;
    localparam int CHUNK = 32;
    localparam int TMO   = 64;
    localparam int D     = 1 << BW;
    localparam int PM    = (1 << (BW + 1)) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          hst_en;
    logic          hst_rdy;
    logic          activity;
    logic [BW:0]   committed_prod;
    logic [BW:0]   committed_cons;
    logic          cred_add;
    logic [7:0]    credits;
    logic          dma_req;
    logic [BW-1:0] dma_addr;
    logic [BW:0]   dma_qw;
    logic          dma_ack;
    logic          dma_done;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit m_rdy, m_arm, m_req, m_xfer;
    int m_cons, m_cred, m_idle, m_addr, m_qw;

    ibuf_drain_sched #(
        .BW       (BW),
        .CHUNK_QW (CHUNK),
        .IDLE_TMO (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hst_en         (hst_en),
        .hst_rdy        (hst_rdy),
        .activity       (activity),
        .committed_prod (committed_prod),
        .committed_cons (committed_cons),
        .cred_add       (cred_add),
        .credits        (credits),
        .dma_req        (dma_req),
        .dma_addr       (dma_addr),
        .dma_qw         (dma_qw),
        .dma_ack        (dma_ack),
        .dma_done       (dma_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Predict the state after the coming edge from the current inputs.
    task automatic model_step();
        int  pending, room, len;
        bit  waiting, idle_st, disp;
        bit  n_rdy, n_arm, n_req, n_xfer;
        int  n_cons, n_cred, n_idle, n_addr, n_qw;
        if (rst) begin
            m_rdy = 0; m_arm = 0; m_req = 0; m_xfer = 0;
            m_cons = 0; m_cred = 0; m_idle = 0; m_addr = 0; m_qw = 0;
            return;
        end
        pending = (int'(committed_prod) - m_cons) & PM;
        room    = D - (m_cons % D);
        len     = pending;
        if (CHUNK < len) len = CHUNK;
        if (room < len)  len = room;
        waiting = m_rdy && !m_req && !m_xfer;
        idle_st = !m_rdy && !m_arm && !m_req && !m_xfer;
        disp    = waiting && hst_en && (m_cred != 0) && (pending != 0) &&
                  ((len == CHUNK) || (len == room) || (m_idle == TMO));

        n_rdy = m_rdy; n_arm = m_arm; n_req = m_req; n_xfer = m_xfer;
        n_cons = m_cons; n_addr = m_addr; n_qw = m_qw;

        n_idle = (activity || disp) ? 0 : ((m_idle < TMO) ? m_idle + 1 : TMO);
        if (disp && cred_add)   n_cred = m_cred;
        else if (disp)          n_cred = m_cred - 1;
        else if (cred_add)      n_cred = (m_cred < 255) ? m_cred + 1 : 255;
        else                    n_cred = m_cred;

        if (m_arm) begin
            n_rdy = 1; n_arm = 0;
        end else if (idle_st && hst_en) begin
            n_arm = 1;
        end
        if (waiting && !hst_en) n_rdy = 0;
        if (disp) begin
            n_req = 1; n_addr = m_cons % D; n_qw = len;
        end
        if (m_req) begin
            if (!hst_en) n_rdy = 0;
            if (dma_ack) begin n_req = 0; n_xfer = 1; end
        end
        if (m_xfer) begin
            if (!hst_en) n_rdy = 0;
            if (dma_done) begin
                n_cons = (m_cons + m_qw) & PM;
                n_xfer = 0;
            end
        end
        m_rdy = n_rdy; m_arm = n_arm; m_req = n_req; m_xfer = n_xfer;
        m_cons = n_cons; m_cred = n_cred; m_idle = n_idle; m_addr = n_addr; m_qw = n_qw;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("cyc_hst_rdy", hst_rdy, m_rdy);
        chk("cyc_dma_req", dma_req, m_req);
        chk("cyc_dma_addr", dma_addr, m_addr);
        chk("cyc_dma_qw", dma_qw, m_qw);
        chk("cyc_cons", committed_cons, m_cons);
        chk("cyc_credits", credits, m_cred);
    endtask

    // Wait (bounded) for a request, report its fields, then ack and complete it.
    task automatic serve(output int a, output int q);
        int k = 0;
        while (dma_req !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        chk("req_seen", dma_req, 1);
        a = int'(dma_addr);
        q = int'(dma_qw);
        tick();
        dma_ack = 1; tick(); dma_ack = 0;
        tick(); tick();
        dma_done = 1; tick(); dma_done = 0;
    endtask

    initial begin
        int a, q, seen, iter, pend;
        rst = 1; hst_en = 0; activity = 0; committed_prod = '0;
        cred_add = 0; dma_ack = 0; dma_done = 0;
        tick(); tick();

        // 1. reset state, arm latency, no request without credits
        chk("rst_cons", committed_cons, 0);
        chk("rst_credits", credits, 0);
        chk("rst_req", dma_req, 0);
        rst = 0; hst_en = 1;
        tick(); chk("arm_rdy_early", hst_rdy, 0);
        tick(); chk("arm_rdy", hst_rdy, 1);
        committed_prod = 11'd40; activity = 1; tick(); activity = 0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin tick(); if (dma_req) seen++; end
        chk("no_req_no_credit", seen, 0);

        // 2. full chunk then idle-flushed partial chunk
        cred_add = 1; tick(); tick(); cred_add = 0;
        serve(a, q);
        chk("t2_addr0", a, 0); chk("t2_qw0", q, 32);
        chk("t2_cons32", committed_cons, 32);
        serve(a, q);
        chk("t2_addr1", a, 32); chk("t2_qw1", q, 8);
        chk("t2_cons40", committed_cons, 40);
        chk("t2_cred0", credits, 0);

        // 3. ibuf wrap
        cred_add = 1; for (int i = 0; i < 40; i++) tick(); cred_add = 0;
        committed_prod = 11'h3F8; activity = 1; tick(); activity = 0;
        iter = 0;
        while (m_cons != 'h3F8 && iter < 40) begin serve(a, q); iter++; end
        chk("t3_cons3f8", committed_cons, 'h3F8);
        committed_prod = 11'h410; activity = 1; tick(); activity = 0;
        serve(a, q);
        chk("t3_wrap_addr", a, 'h3F8); chk("t3_wrap_qw", q, 8);
        chk("t3_cons400", committed_cons, 'h400);
        serve(a, q);
        chk("t3_post_addr", a, 0); chk("t3_post_qw", q, 16);
        chk("t3_cons410", committed_cons, 'h410);

        // 4. cred_add on dispatch cycle, saturation
        rst = 1; tick(); rst = 0;
        committed_prod = 11'd32; activity = 1; tick(); activity = 0;
        tick(); tick(); tick();
        cred_add = 1; tick(); tick(); cred_add = 0;
        chk("t4_dispatch", dma_req, 1);
        chk("t4_cred_kept", credits, 1);
        serve(a, q);
        hst_en = 0;
        cred_add = 1; for (int i = 0; i < 260; i++) tick(); cred_add = 0;
        chk("t4_cred_sat", credits, 255);

        // 5. host drops during XFER
        hst_en = 1; tick(); tick(); tick();
        committed_prod = 11'd72; activity = 1; tick(); activity = 0;
        iter = 0;
        while (dma_req !== 1'b1 && iter < 300) begin tick(); iter++; end
        chk("t5_req", dma_req, 1);
        dma_ack = 1; tick(); dma_ack = 0;
        hst_en = 0; tick();
        chk("t5_rdy_drop", hst_rdy, 0);
        tick();
        dma_done = 1; tick(); dma_done = 0;
        chk("t5_cons", committed_cons, 64);
        seen = 0;
        for (int i = 0; i < 100; i++) begin tick(); if (dma_req) seen++; end
        chk("t5_no_req", seen, 0);
        hst_en = 1; tick();
        chk("t5_idle_rdy0", hst_rdy, 0);
        tick();
        chk("t5_rearm_rdy", hst_rdy, 1);

        // 6. reset while a request is pending
        iter = 0;
        while (dma_req !== 1'b1 && iter < 300) begin tick(); iter++; end
        chk("t6_req", dma_req, 1);
        rst = 1; tick(); rst = 0;
        chk("t6_req0", dma_req, 0);
        chk("t6_cons0", committed_cons, 0);
        chk("t6_cred0", credits, 0);
        chk("t6_rdy0", hst_rdy, 0);

        // 7. randomized traffic against the model
        committed_prod = '0; tick();
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 199) == 0) hst_en = ~hst_en;
            cred_add = ($urandom_range(0, 7) == 0);
            dma_ack  = ($urandom_range(0, 2) == 0);
            dma_done = ($urandom_range(0, 3) == 0);
            activity = ($urandom_range(0, 2) == 0);
            if (activity) begin
                pend = (int'(committed_prod) - m_cons) & PM;
                committed_prod = committed_prod +
                    (BW+1)'($urandom_range(0, (D - pend < 8) ? D - pend : 8));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
